// File: rtl/move_pkg.sv
// Shared constants for the move request generator: debouncer state
// encodings, direction codes (which double as button indices) and the
// width of the dropped-press counter.
package move_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int DROP_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchroniser, press/release
// debouncer FSM and, when MOVE_AUTO_REPEAT_EN is defined, an auto-repeat
// timer. Emits a one-cycle registered press event per accepted press.
// A button already held when reset is released is ignored until it has
// been seen released at least once.
module btn_debounce
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat intervals >= 1");
  end

  logic             sync_p0, sync_p1;
  logic [1:0]       warm;
  logic             armed;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             press_nxt;
  logic             rpt_fire;

  assign cnt_inc = cnt + CNT_ONE;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Arm only once the synchroniser holds a real sample showing release
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else if (warm != 2'd2) begin
      warm <= warm + 2'd1;
    end else if (!sync_p1) begin
      armed <= 1'b1;
    end
  end

  // Debouncer next-state: any bounce restarts the stability count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && sync_p1) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_p1) begin
          state_nxt = ST_IDLE;
        end else if (cnt_inc == CNT_LAST) begin
          state_nxt = ST_HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!sync_p1) begin
          state_nxt = ST_REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_REL_WAIT: begin
        if (sync_p1) begin
          state_nxt = ST_HELD;
        end else if (cnt_inc == CNT_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Debouncer state, counter and registered press event
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt | rpt_fire;
    end
  end

`ifdef MOVE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt, rpt_inc, rpt_lim;
  logic             rpt_first;
  logic             in_held;

  assign in_held  = (state == ST_HELD) && sync_p1;
  assign rpt_inc  = rpt_cnt + RPT_ONE;
  assign rpt_lim  = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
  assign rpt_fire = in_held && (rpt_inc == rpt_lim);

  // Repeat timer: first interval is the long delay, then the period;
  // anything other than a steady hold restarts it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (!in_held) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_inc;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/move_request_gen.sv
// Move request generator for the 2048 controller: four debounced buttons,
// fixed-priority arbitration (U > D > L > R), a one-entry pending slot
// drained only when the controller is ready, registered one-cycle move
// pulses and a saturating count of discarded presses.
// Optional feature macro: MOVE_AUTO_REPEAT_EN (auto-repeat while held).
module move_request_gen
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BtnU,
  input  logic              BtnD,
  input  logic              BtnL,
  input  logic              BtnR,
  input  logic              ready,
  output logic              up,
  output logic              down,
  output logic              left,
  output logic              right,
  output logic              pending,
  output logic [DROP_W-1:0] drop_count
);

  logic [3:0] btn_raw;
  logic [3:0] press;
  logic       win_vld;
  logic [1:0] win_dir;
  logic [2:0] n_press;
  logic [2:0] n_drop;
  logic       slot_vld;
  logic [1:0] slot_dir;
  logic       issue;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [2:0]        b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-2){1'b0}}, b};
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

  // Button index equals its direction code
  assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_deb (
      .Clk   (Clk),
      .Reset (Reset),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  // Arbitration: pick the highest-priority event, count the rest as drops
  always_comb begin
    win_vld = |press;
    win_dir = DIR_RIGHT;
    if (press[DIR_UP])        win_dir = DIR_UP;
    else if (press[DIR_DOWN]) win_dir = DIR_DOWN;
    else if (press[DIR_LEFT]) win_dir = DIR_LEFT;
    n_press = {2'b00, press[0]} + {2'b00, press[1]} + {2'b00, press[2]} + {2'b00, press[3]};
    if (slot_vld)     n_drop = n_press;
    else if (win_vld) n_drop = n_press - 3'd1;
    else              n_drop = 3'd0;
  end

  assign issue   = slot_vld && ready;
  assign pending = slot_vld;

  // Pending slot and move pulses; a full slot refuses events even while issuing
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot_vld <= 1'b0;
      slot_dir <= DIR_UP;
      up       <= 1'b0;
      down     <= 1'b0;
      left     <= 1'b0;
      right    <= 1'b0;
    end else begin
      up    <= issue && (slot_dir == DIR_UP);
      down  <= issue && (slot_dir == DIR_DOWN);
      left  <= issue && (slot_dir == DIR_LEFT);
      right <= issue && (slot_dir == DIR_RIGHT);
      if (slot_vld) begin
        if (ready) slot_vld <= 1'b0;
      end else if (win_vld) begin
        slot_vld <= 1'b1;
        slot_dir <= win_dir;
      end
    end
  end

  // Saturating dropped-press counter, cleared only by reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) drop_count <= '0;
    else       drop_count <= sat_add(drop_count, n_drop);
  end

endmodule

// File: tb/tb_move_request_gen.sv
// Bench for move_request_gen: directed scenarios with fixed expected pulse
// timing, plus randomized button/ready activity compared every cycle with a
// behavioural model (run-length debounce, priority pick, one-entry slot).
module tb_move_request_gen;

  localparam int DEB   = 4;
  localparam int RDLY  = 20;
  localparam int RPER  = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic       ready = 1'b0;
  logic       up, down, left, right, pending;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  move_request_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnU       (BtnU),
    .BtnD       (BtnD),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .ready      (ready),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .pending    (pending),
    .drop_count (drop_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_hist[4][$];
  int m_acc[4], m_run[4], m_arm[4], m_ev[4];
  int m_el[4], m_thr[4];
  int m_slot, m_out, m_drop;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hist[i].delete();
      m_acc[i] = 0; m_run[i] = 0; m_arm[i] = 0; m_ev[i] = 0;
      m_el[i] = 0;  m_thr[i] = RDLY;
    end
    m_slot = -1; m_out = -1; m_drop = 0;
  endtask

  task automatic model_step();
    int raw[4];
    int nev[4];
    int prev_slot, n, w, s;
    raw[0] = int'(BtnU); raw[1] = int'(BtnD); raw[2] = int'(BtnL); raw[3] = int'(BtnR);
    prev_slot = m_slot;
    m_out = -1;
    if (m_slot >= 0 && ready) begin
      m_out  = m_slot;
      m_slot = -1;
    end
    n = 0; w = -1;
    for (int i = 0; i < 4; i++) if (m_ev[i] != 0) begin n++; if (w < 0) w = i; end
    if (prev_slot >= 0) m_drop += n;
    else if (n > 0) begin m_slot = w; m_drop += n - 1; end
    if (m_drop > 255) m_drop = 255;
    for (int i = 0; i < 4; i++) begin
      nev[i] = 0;
      m_hist[i].push_back(raw[i]);
      if (m_hist[i].size() > 3) void'(m_hist[i].pop_front());
      if (m_hist[i].size() == 3) begin
        s = m_hist[i][0];
        if (m_arm[i] == 0) begin
          if (s == 0) m_arm[i] = 1;
        end else if (s != m_acc[i]) begin
          m_run[i]++;
          m_el[i] = 0; m_thr[i] = RDLY;
          if (m_run[i] == DEB) begin
            m_acc[i] = s; m_run[i] = 0;
            if (s == 1) nev[i] = 1;
          end
        end else begin
`ifdef MOVE_AUTO_REPEAT_EN
          if (m_acc[i] == 1 && m_run[i] == 0) begin
            m_el[i]++;
            if (m_el[i] == m_thr[i]) begin nev[i] = 1; m_el[i] = 0; m_thr[i] = RPER; end
          end
`endif
          m_run[i] = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) m_ev[i] = nev[i];
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else       model_step();
  end

  always @(negedge Clk) begin
    if (chk_en && !Reset) begin
      chk("m_up",      int'(up),    int'(m_out == 0));
      chk("m_down",    int'(down),  int'(m_out == 1));
      chk("m_left",    int'(left),  int'(m_out == 2));
      chk("m_right",   int'(right), int'(m_out == 3));
      chk("m_pending", int'(pending), int'(m_slot >= 0));
      chk("m_drop",    int'(drop_count), m_drop);
      chk("m_onehot",  int'(up) + int'(down) + int'(left) + int'(right) <= 1 ? 1 : 0, 1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_pulse;
    repeat (3) @(negedge Clk);
    chk("rst_up", int'(up), 0);
    chk("rst_right", int'(right), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop", int'(drop_count), 0);
    #2 Reset = 1'b0;
    chk_en = 1'b1;
    idle(10);

    // clean press
    ready = 1'b1; BtnU = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge Clk);
      chk("clean_up", int'(up), int'(e == 8));
    end
    BtnU = 1'b0;
    idle(20);

    // bounce then stable
    for (int p = 0; p < 4; p++) begin
      BtnL = (p % 2 == 0);
      @(negedge Clk);
      chk("bounce_quiet", int'(left), 0);
    end
    BtnL = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge Clk);
      chk("bounce_left", int'(left), int'(e == 8));
    end
    BtnL = 1'b0;
    idle(20);

    // not ready
    ready = 1'b0; BtnD = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge Clk);
      chk("nr_down_wait", int'(down), 0);
      if (c == 10) BtnD = 1'b0;
    end
    chk("nr_pending", int'(pending), 1);
    ready = 1'b1;
    @(negedge Clk);
    chk("nr_down_go", int'(down), 1);
    chk("nr_pending_clr", int'(pending), 0);
    idle(10);

    // simultaneous U and R
    BtnU = 1'b1; BtnR = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge Clk);
      chk("sim_up", int'(up), int'(e == 8));
      chk("sim_right", int'(right), 0);
    end
    chk("sim_drop", int'(drop_count), 1);
    BtnU = 1'b0; BtnR = 1'b0;
    idle(20);
    ready = 1'b0;
    BtnD = 1'b1; idle(10); BtnD = 1'b0; idle(10);
    BtnL = 1'b1; idle(10); BtnL = 1'b0; idle(10);
    chk("full_drop", int'(drop_count), 2);
    chk("full_pending", int'(pending), 1);

    // reset mid-operation: flush DOWN, latch LEFT, start R debounce
    ready = 1'b1; @(negedge Clk);
    chk("flush_down", int'(down), 1);
    ready = 1'b0;
    BtnL = 1'b1; idle(10); BtnL = 1'b0; idle(10);
    chk("rst_slot_left", int'(pending), 1);
    BtnR = 1'b1; idle(4);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_pending", int'(pending), 0);
    chk("rst_mid_drop", int'(drop_count), 0);
    chk("rst_mid_outs", int'(up) + int'(down) + int'(left) + int'(right), 0);
    idle(3);
    #2 Reset = 1'b0;
    ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      chk("held_thru_rst", int'(right), 0);
    end
    BtnR = 1'b0; idle(15);
    BtnR = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge Clk);
      chk("repress_right", int'(right), int'(e == 8));
    end
    BtnR = 1'b0; idle(20);

    // long hold: auto-repeat when enabled, single pulse otherwise
    BtnU = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      @(negedge Clk);
`ifdef MOVE_AUTO_REPEAT_EN
      exp_pulse = int'(e == 8 || (e >= 28 && e <= 60 && (e - 28) % 8 == 0));
`else
      exp_pulse = int'(e == 8);
`endif
      chk("hold_up", int'(up), exp_pulse);
      if (e == 60) BtnU = 1'b0;
    end
    idle(20);

    // randomized activity, checked by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 7) == 0) BtnU = ~BtnU;
      if ($urandom_range(0, 7) == 0) BtnD = ~BtnD;
      if ($urandom_range(0, 7) == 0) BtnL = ~BtnL;
      if ($urandom_range(0, 7) == 0) BtnR = ~BtnR;
      ready = ($urandom_range(0, 3) != 0);
    end
    BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
    idle(20);

    // drive drop_count into saturation
    ready = 1'b0;
    for (int k = 0; k < 70; k++) begin
      BtnU = 1'b1; BtnD = 1'b1; BtnL = 1'b1; BtnR = 1'b1;
      idle(6);
      BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
      idle(6);
    end
    idle(10);
    chk("drop_sat", int'(drop_count), 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
